// File: rtl/i2s_slave_if.sv
// i2s_slave_if: I2S bus plus sample-side handshake between an I2S master
// (bclk/lrclk/sdin driver, tx sample source, rx sample sink) and i2s_slave.
//   bclk, lrclk, sdin : serial bus from the master (asynchronous to clock)
//   sdout             : serial data back to the master
//   tx_real/tx_imag   : samples to transmit, tx_ready pulses when latched
//   rx_real/rx_imag   : last received words, rx_valid pulses on update
//   frame_err         : slot-length violation pulse; locked: frame-aligned
`timescale 1ns/1ps
interface i2s_slave_if #(
  parameter int unsigned RX_WIDTH = 24,
  parameter int unsigned TX_WIDTH = 16
);
  logic                bclk;
  logic                lrclk;
  logic                sdin;
  logic                sdout;
  logic [TX_WIDTH-1:0] tx_real;
  logic [TX_WIDTH-1:0] tx_imag;
  logic                tx_ready;
  logic [RX_WIDTH-1:0] rx_real;
  logic [RX_WIDTH-1:0] rx_imag;
  logic                rx_valid;
  logic                frame_err;
  logic                locked;

  modport slave (
    input  bclk, lrclk, sdin, tx_real, tx_imag,
    output sdout, tx_ready, rx_real, rx_imag, rx_valid, frame_err, locked
  );

  modport master (
    output bclk, lrclk, sdin, tx_real, tx_imag,
    input  sdout, tx_ready, rx_real, rx_imag, rx_valid, frame_err, locked
  );
endinterface

// File: rtl/i2s_slave.sv
// i2s_slave: codec-side I2S slave (Philips timing) oversampling BCLK/LRCLK
// on the system clock. Deserialises RX_WIDTH-bit left/right words and
// serialises TX_WIDTH-bit real/imag samples back to the master.
//   clock : system clock, at least 8x BCLK
//   reset : synchronous, active-high
//   bus   : i2s_slave_if slave modport (serial bus + sample handshake)
`timescale 1ns/1ps
module i2s_slave #(
  parameter int unsigned RX_WIDTH = 24,
  parameter int unsigned TX_WIDTH = 16,
  parameter int unsigned SLOT     = 32
) (
  input  logic       clock,
  input  logic       reset,
  i2s_slave_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(SLOT + 1);
  localparam logic [CNT_W-1:0] SLOT_MAX  = CNT_W'(SLOT);
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT - 1);
  localparam logic [CNT_W-1:0] RX_LAST   = CNT_W'(RX_WIDTH);
  localparam logic [CNT_W-1:0] RX_PRE    = CNT_W'(RX_WIDTH - 1);
  localparam logic [CNT_W-1:0] TX_LEN    = CNT_W'(TX_WIDTH);

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } state_t;

  state_t              state_q;
  // [0],[1] synchroniser stages, [2] history
  logic [2:0]          bclk_q;
  logic [2:0]          lr_q;
  logic [2:0]          sd_q;
  logic                lr_prev_q;
  logic [CNT_W-1:0]    bit_cnt_q;
  logic [RX_WIDTH-1:0] sh_q;
  logic [RX_WIDTH-1:0] held_left_q;
  logic [RX_WIDTH-1:0] rx_real_q;
  logic [RX_WIDTH-1:0] rx_imag_q;
  logic                rx_pend_q;
  logic                rx_valid_q;
  logic [TX_WIDTH-1:0] tx_sh_q;
  logic [TX_WIDTH-1:0] tx_im_q;
  logic                tx_ready_q;
  logic                sdout_q;
  logic                frame_err_q;
  logic                locked_q;

  logic             rise_c;
  logic             fall_c;
  logic             lr_c;
  logic             sd_c;
  logic             boundary_c;
  logic             err_c;
  logic             enter_left_c;
  logic             enter_right_c;
  logic [CNT_W-1:0] cnt_inc_c;

  // Edge detect and rise-time decisions
  assign rise_c        = bclk_q[1] & ~bclk_q[2];
  assign fall_c        = ~bclk_q[1] & bclk_q[2];
  assign lr_c          = lr_q[2];
  assign sd_c          = sd_q[2];
  assign boundary_c    = rise_c & (lr_c != lr_prev_q);
  assign err_c         = boundary_c & (state_q != SYNC) & (bit_cnt_q != SLOT_LAST);
  // A falling-LRCLK boundary always (re)starts a frame, even on an error
  assign enter_left_c  = boundary_c & ~lr_c;
  assign enter_right_c = boundary_c & lr_c & (state_q == LEFT) & ~err_c;
  assign cnt_inc_c     = (bit_cnt_q == SLOT_MAX) ? bit_cnt_q : bit_cnt_q + CNT_W'(1);

  // Frame FSM, receive shifter and transmit serialiser
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= SYNC;
      bclk_q      <= '0;
      lr_q        <= '0;
      sd_q        <= '0;
      lr_prev_q   <= 1'b0;
      bit_cnt_q   <= '0;
      sh_q        <= '0;
      held_left_q <= '0;
      rx_real_q   <= '0;
      rx_imag_q   <= '0;
      rx_pend_q   <= 1'b0;
      rx_valid_q  <= 1'b0;
      tx_sh_q     <= '0;
      tx_im_q     <= '0;
      tx_ready_q  <= 1'b0;
      sdout_q     <= 1'b0;
      frame_err_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      bclk_q      <= {bclk_q[1:0], bus.bclk};
      lr_q        <= {lr_q[1:0], bus.lrclk};
      sd_q        <= {sd_q[1:0], bus.sdin};
      tx_ready_q  <= 1'b0;
      frame_err_q <= 1'b0;
      rx_pend_q   <= 1'b0;
      rx_valid_q  <= rx_pend_q;

      if (rise_c) begin
        lr_prev_q <= lr_c;
        if (boundary_c) begin
          // The bit on a boundary rise closes the previous slot; no capture
          bit_cnt_q   <= '0;
          frame_err_q <= err_c;
          if (enter_left_c) begin
            state_q    <= LEFT;
            locked_q   <= 1'b1;
            tx_sh_q    <= bus.tx_real;
            tx_im_q    <= bus.tx_imag;
            tx_ready_q <= 1'b1;
          end else if (enter_right_c) begin
            state_q     <= RIGHT;
            held_left_q <= sh_q;
            tx_sh_q     <= tx_im_q;
          end else if (err_c) begin
            state_q  <= SYNC;
            locked_q <= 1'b0;
          end
        end else begin
          bit_cnt_q <= cnt_inc_c;
          if ((state_q != SYNC) && (bit_cnt_q < RX_LAST)) begin
            sh_q <= {sh_q[RX_WIDTH-2:0], sd_c};
            // Last RX bit of the right slot completes the frame
            if ((state_q == RIGHT) && (bit_cnt_q == RX_PRE)) begin
              rx_real_q <= held_left_q;
              rx_imag_q <= {sh_q[RX_WIDTH-2:0], sd_c};
              rx_pend_q <= 1'b1;
            end
          end
        end
      end else if (fall_c) begin
        if ((state_q != SYNC) && (bit_cnt_q < TX_LEN)) begin
          sdout_q <= tx_sh_q[TX_WIDTH-1];
          tx_sh_q <= {tx_sh_q[TX_WIDTH-2:0], 1'b0};
        end else begin
          sdout_q <= 1'b0;
        end
      end
    end
  end

  assign bus.sdout     = sdout_q;
  assign bus.tx_ready  = tx_ready_q;
  assign bus.rx_real   = rx_real_q;
  assign bus.rx_imag   = rx_imag_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.locked    = locked_q;

endmodule

// File: tb/tb_i2s_slave.sv
// tb_i2s_slave: I2S master model streaming directed slots into i2s_slave,
// with a scoreboard queue of expected RX frames checked by a monitor.
`timescale 1ns/1ps
module tb_i2s_slave;

  logic clk = 1'b0;
  logic reset;

  i2s_slave_if #(.RX_WIDTH(24), .TX_WIDTH(16)) bus ();

  i2s_slave #(.RX_WIDTH(24), .TX_WIDTH(16), .SLOT(32)) dut (
    .clock (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_txr   = 0;
  int n_err   = 0;
  int n_lslot = 0;
  logic [47:0] sb_q[$];
  logic [23:0] last_left;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One-cycle reset pulse, then everything must be back at reset values
  task automatic pulse_reset();
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    check("rst_locked", 48'(bus.locked), 48'h0);
    check("rst_rx", {bus.rx_real, bus.rx_imag}, 48'h0);
    check("rst_pulses", 48'({bus.sdout, bus.tx_ready, bus.rx_valid, bus.frame_err}), 48'h0);
  endtask

  // One channel slot; position 0 carries the previous slot's last bit
  task automatic send_slot(input bit lr, input logic [23:0] word, input int len,
                           input int rst_at, input bit chk_tx, input logic [15:0] exp_tx,
                           input bit exp_lock, input bit exp_rx, input int half);
    logic [23:0] sh;
    logic [15:0] dec;
    logic        trail;
    sh    = word;
    dec   = '0;
    trail = 1'b0;
    if (!lr) begin
      last_left = word;
      n_lslot++;
    end
    if (lr && exp_rx) sb_q.push_back({last_left, word});
    for (int j = 0; j < len; j++) begin
      bus.bclk  = 1'b0;
      bus.lrclk = lr;
      if (j >= 1 && j <= 24) begin
        bus.sdin = sh[23];
        sh       = {sh[22:0], 1'b0};
      end else begin
        bus.sdin = 1'b0;
      end
      if (j == rst_at) pulse_reset();
      #(half);
      bus.bclk = 1'b1;
      if (j >= 1 && j <= 16) dec = {dec[14:0], bus.sdout};
      else if (j > 16) trail = trail | bus.sdout;
      if (j == len - 1) check("lock", 48'(bus.locked), 48'(exp_lock));
      #(half);
    end
    if (chk_tx) begin
      check("tx_word", 48'(dec), 48'(exp_tx));
      check("tx_trail", 48'(trail), 48'h0);
    end
  endtask

  task automatic frame(input logic [23:0] l, input logic [23:0] r,
                       input logic [15:0] txr, input logic [15:0] txi, input int half);
    bus.tx_real = txr;
    bus.tx_imag = txi;
    send_slot(1'b0, l, 32, -1, 1'b1, txr, 1'b1, 1'b0, half);
    send_slot(1'b1, r, 32, -1, 1'b1, txi, 1'b1, 1'b1, half);
  endtask

  // Scoreboard monitor and pulse counters
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.rx_valid) begin
        check("rx_tx_coincide", 48'(bus.tx_ready), 48'h0);
        if (sb_q.size() == 0) begin
          check("rx_unexpected", 48'(bus.rx_valid), 48'h0);
        end else begin
          logic [47:0] e;
          e = sb_q.pop_front();
          check("rx_real", 48'(bus.rx_real), 48'(e[47:24]));
          check("rx_imag", 48'(bus.rx_imag), 48'(e[23:0]));
        end
      end
      if (bus.tx_ready) n_txr++;
      if (bus.frame_err) n_err++;
    end
  end

  initial begin
    reset       = 1'b1;
    bus.bclk    = 1'b0;
    bus.lrclk   = 1'b0;
    bus.sdin    = 1'b0;
    bus.tx_real = 16'h8001;
    bus.tx_imag = 16'h7FFE;
    repeat (5) @(negedge clk);
    check("init_locked", 48'(bus.locked), 48'h0);
    check("init_rx_real", 48'(bus.rx_real), 48'h0);
    check("init_rx_imag", 48'(bus.rx_imag), 48'h0);
    check("init_sdout", 48'(bus.sdout), 48'h0);
    check("init_pulses", 48'({bus.tx_ready, bus.rx_valid, bus.frame_err}), 48'h0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Right-slot preamble so the first left slot starts at a falling LRCLK
    send_slot(1'b1, 24'h0, 32, -1, 1'b1, 16'h0, 1'b0, 1'b0, 50);
    frame(24'hA5A5A5, 24'h5A5A5A, 16'h8001, 16'h7FFE, 50);
    frame(24'hA5A5A5, 24'h5A5A5A, 16'h8001, 16'h7FFE, 53);
    frame(24'hA5A5A5, 24'h5A5A5A, 16'h8001, 16'h7FFE, 47);
    frame(24'hFFFFFF, 24'h000000, 16'h8001, 16'h7FFE, 57);
    frame(24'h800001, 24'h123456, 16'h1234, 16'hABCD, 44);

    // Left slot shortened to 30 BCLKs: error, discard, relock next frame
    bus.tx_real = 16'h8001;
    bus.tx_imag = 16'h7FFE;
    send_slot(1'b0, 24'h111111, 30, -1, 1'b1, 16'h8001, 1'b1, 1'b0, 50);
    send_slot(1'b1, 24'h222222, 32, -1, 1'b1, 16'h0000, 1'b0, 1'b0, 50);
    frame(24'h333333, 24'h444444, 16'h8001, 16'h7FFE, 61);
    frame(24'hA5A5A5, 24'h5A5A5A, 16'h8001, 16'h7FFE, 50);

    // Reset for one cycle mid-LEFT
    send_slot(1'b0, 24'h555555, 32, 10, 1'b0, 16'h0, 1'b0, 1'b0, 50);
    send_slot(1'b1, 24'h666666, 32, -1, 1'b1, 16'h0, 1'b0, 1'b0, 50);
    frame(24'hABCDEF, 24'hFEDCBA, 16'hFFFF, 16'h0001, 53);

    // Reset released mid-RIGHT: that frame is lost, lock at next LRCLK fall
    send_slot(1'b0, 24'h777777, 32, -1, 1'b1, 16'hFFFF, 1'b1, 1'b0, 50);
    send_slot(1'b1, 24'h888888, 32, 12, 1'b0, 16'h0, 1'b0, 1'b0, 50);
    frame(24'h0F0F0F, 24'hF0F0F0, 16'h8001, 16'h7FFE, 47);

    // Closing left slot validates the last right slot's length
    send_slot(1'b0, 24'h0, 32, -1, 1'b1, 16'h8001, 1'b1, 1'b0, 50);
    repeat (20) @(negedge clk);

    check("rx_missing", 48'(sb_q.size()), 48'h0);
    check("tx_ready_count", 48'(n_txr), 48'(n_lslot));
    check("frame_err_count", 48'(n_err), 48'h1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_slave.md
Name: i2s_slave

Overview:
- Far end of the transceiver's I2S master bus: codec-side I2S slave.
- Oversamples BCLK/LRCLK on a faster system clock.
- Deserialises the master's serial output into 24-bit real/imag RX words.
- Serialises 16-bit real/imag TX samples back onto the master's serial input.
- Serves as the bus-functional counterpart for the MCU-side audio interface and as the loopback partner in transceiver benches.

Parameters:
RX_WIDTH, 24, bits per received word, MSB first; remaining slot bits ignored
TX_WIDTH, 16, bits per transmitted word, MSB first; remaining slot bits driven 0
SLOT, 32, BCLK periods per channel slot; must be ≥ max(RX_WIDTH, TX_WIDTH)+1

Ports:
clock  in  1  system clock, ≥ 8x BCLK frequency
reset  in  1  synchronous, active-high
bclk  in  1  bit clock from the master, asynchronous
lrclk  in  1  word select from the master, asynchronous; 0 = left/real, 1 = right/imag
sdin  in  1  serial data from the master (FPGA DOUT)
sdout  out  1  serial data to the master (FPGA DIN)
tx_real  in  TX_WIDTH  real sample to send; latched at frame start
tx_imag  in  TX_WIDTH  imag sample to send; latched at frame start
tx_ready  out  1  one-cycle pulse when tx_real/tx_imag are latched
rx_real  out  RX_WIDTH  last complete received real word
rx_imag  out  RX_WIDTH  last complete received imag word
rx_valid  out  1  one-cycle pulse when rx_real/rx_imag update
frame_err  out  1  one-cycle pulse on a slot-length violation
locked  out  1  high while aligned to frames

Behaviour:
- Input conditioning:
  - bclk, lrclk and sdin each pass through a 2-FF synchroniser plus one history FF.
  - rise = one-cycle pulse on a synchronised 0→1 BCLK transition; fall = one-cycle pulse on a 1→0 transition.
- On each rise:
  - Sample lr and sd.
  - boundary = lr differs from lr sampled at the previous rise.
- Philips timing:
  - The bit sampled on the boundary rise is the last bit of the previous slot.
  - MSB is sampled on the following rise.
- bit_cnt:
  - Set to 0 on a boundary rise; otherwise increments on each rise, saturating at SLOT.
  - A data bit with index i (MSB = 1) is captured when bit_cnt becomes i, for i in 1..RX_WIDTH, shifting MSB first.
- States: SYNC, LEFT, RIGHT.
  - SYNC → LEFT on a boundary rise with lr = 0.
  - LEFT → RIGHT on a boundary rise with lr = 1.
  - RIGHT → LEFT on a boundary rise with lr = 0.
  - Boundaries are ignored in SYNC except the falling-LRCLK one.
  - locked = (state != SYNC).
- Slot length check (LEFT/RIGHT only):
  - At each boundary rise, bit_cnt must equal SLOT-1.
  - Otherwise pulse frame_err, discard the frame in progress (no rx_valid), and enter SYNC.
  - If the erroring boundary is itself a falling-LRCLK boundary, enter LEFT directly in the same cycle.
- Receive:
  - At the end of LEFT (boundary to RIGHT), the left shift register is copied to a held-left register.
  - In RIGHT, on the rise where bit_cnt becomes RX_WIDTH:
    - rx_real <= held-left; rx_imag <= right shift register.
    - rx_valid pulses one cycle later.
  - rx_valid is only produced for frames whose LEFT slot was fully received while locked.
- Transmit:
  - On every boundary rise into LEFT (including from SYNC), latch tx_real and tx_imag and pulse tx_ready in the same cycle.
  - On each fall in LEFT/RIGHT with bit_cnt = k, k < TX_WIDTH: sdout <= bit TX_WIDTH-1-k of the latched word (real in LEFT, imag in RIGHT).
  - On each fall with k ≥ TX_WIDTH: sdout <= 0.
  - In SYNC, sdout = 0.
  - sdout update latency: ≤ 4 clock cycles after the external BCLK falling edge.
- Reset values:
  - sdout, tx_ready, rx_valid, frame_err, locked = 0.
  - rx_real, rx_imag = 0; state = SYNC; bit_cnt = 0.
  - Synchroniser history = 0.
  - Reset mid-frame abandons all partial words.
- Simultaneous events:
  - A boundary rise takes priority over the capture/increment for that rise.
  - tx_ready and rx_valid may not coincide: rx_valid occurs mid-RIGHT, tx_ready at a LEFT boundary.

Test Plan:
- Reset, then master frames: left = 0xA5A5A5, right = 0x5A5A5A, SLOT = 32 → after the first full frame, rx_real = 0xA5A5A5, rx_imag = 0x5A5A5A, exactly one rx_valid per frame, frame_err never asserted.
- tx_real = 0x8001, tx_imag = 0x7FFE held → the bench-decoded DIN stream shows 0x8001 in left and 0x7FFE in right, trailing 16 bits 0, one tx_ready per frame.
- Reset released mid-RIGHT slot → locked stays 0, no rx_valid until a full LEFT+RIGHT frame completes after the next LRCLK falling edge.
- Shorten one LEFT slot to 30 BCLKs → one frame_err pulse, that frame discarded (no rx_valid), lock regained at the next LRCLK falling edge, next frame decoded correctly.
- Assert reset for one cycle mid-LEFT while streaming → all outputs return to reset values, and correct data resumes after the next full frame.
- Loopback with a back-to-back i2s master at s_rate 48k/96k, and BCLK phase swept against clock → bit-exact RX and TX over 1000 frames.
